// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared constants for the 80x30 text-mode renderer: screen geometry, glyph
// size, the blank character written by a clear, the clear/write FSM states
// and the cell-index helper used by the display pipeline.
// ---------------------------------------------------------------------------
package vga_text_pkg;

  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int CELLS   = 2400;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [6:0]  SPACE     = 7'h20;
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // row*80 + col, with row*80 built as row*64 + row*16 so no multiplier
  // is needed in the pixel path.
  function automatic logic [11:0] cell_index(input logic [4:0] row,
                                             input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/vga_text_ram.sv
// ---------------------------------------------------------------------------
// vga_text_ram
// 2400 x 10 character/colour store. One write port, one read port with a
// registered output. A read and a write to the same cell on the same clock
// return the old word.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write cell index (caller guarantees < 2400)
//   i_wdata  in   {fg[2:0], char[6:0]}
//   i_re     in   read enable (loads the output register)
//   i_raddr  in   read cell index; indices >= 2400 read as 0
//   o_rdata  out  registered read word
// ---------------------------------------------------------------------------
module vga_text_ram
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [11:0] i_waddr,
  input  logic [9:0]  i_wdata,
  input  logic        i_re,
  input  logic [11:0] i_raddr,
  output logic [9:0]  o_rdata
);

  logic [9:0] r_mem [0:CELLS-1];
  logic [9:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= (i_raddr < 12'(CELLS)) ? r_mem[i_raddr] : 10'h000;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_text_renderer.sv
// ---------------------------------------------------------------------------
// vga_text_renderer
// Text-mode pixel pipeline between the VGA timing generator and the pins.
// Maps (px_x, px_y) to an 80x30 cell, fetches the cell word from the text
// RAM, addresses the external 8x16 glyph ROM and colours the glyph bit.
// hs/vs travel alongside so they stay aligned with rgb_out (3 strobes).
// Also holds the host write port, the bulk-clear FSM and a blinking cursor.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   pix_en              pixel strobe; the pipeline advances only on it
//   px_x, px_y, de_in   pixel coordinate and active-video flag
//   hs_in, vs_in        syncs in;  hs_out, vs_out delayed copies
//   glyph_addr/data     glyph ROM address out, ROM bit in (1 clk later)
//   rgb_out             pixel colour
//   wr_valid/ready      host write handshake; wr_addr cell, wr_data word
//   wr_err              pulse after an accepted write to a cell >= 2400
//   clear_req/busy/done bulk fill of every cell with a blank
//   cursor_en/addr      cursor enable and cell index
// ---------------------------------------------------------------------------
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter logic [2:0] BG_COLOR      = 3'b000,
  parameter int         BLINK_FRAMES  = 30,
  parameter bit         WR_BLANK_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [13:0] glyph_addr,
  input  logic        glyph_data,
  output logic [2:0]  rgb_out,
  output logic        hs_out,
  output logic        vs_out,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [9:0]  wr_data,
  output logic        wr_err,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr
);

  localparam int             BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [11:0] w_cell;
  logic [11:0] w_rd_addr;
  logic [9:0]  w_ram_q;
  logic        w_unused_y9;
  logic        w_bit;
  logic [2:0]  w_rgb;
  logic        w_wr_acc;
  logic        w_wr_ok;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [9:0]  w_wdata;

  logic        r_de_p1, r_hs_p1, r_vs_p1, r_hit_p1;
  logic [3:0]  r_row_p1;
  logic [2:0]  r_col_p1;
  logic        r_de_p2, r_hs_p2, r_vs_p2, r_hit_p2;
  logic [2:0]  r_fg_p2;
  logic [13:0] r_glyph_addr_p2;
  logic [2:0]  r_rgb_p3;
  logic        r_hs_p3, r_vs_p3;

  logic          r_blink_on;
  logic [BW-1:0] r_blink_cnt;

  state_t      r_state;
  logic [11:0] r_clr_addr;
  logic        r_clear_done;
  logic        r_wr_err;

  // Only 480 visible lines, so px_y[9] never selects a row.
  assign w_unused_y9 = px_y[9];

  // S1: cell index and RAM read. Blanking reads cell 0 so the address bus
  // is quiet outside active video.
  assign w_cell    = cell_index(px_y[8:4], px_x[9:3]);
  assign w_rd_addr = de_in ? w_cell : 12'd0;

  // RAM output register doubles as the S1->S2 word register.
  vga_text_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (pix_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // S3: cursor inverts the glyph bit while the blink phase is on.
  always_comb begin
    w_bit = glyph_data ^ (r_hit_p2 & cursor_en & r_blink_on);
    w_rgb = BG_COLOR;
    if (r_de_p2 && w_bit) begin
      w_rgb = r_fg_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_de_p1         <= 1'b0;
      r_hs_p1         <= 1'b1;
      r_vs_p1         <= 1'b1;
      r_de_p2         <= 1'b0;
      r_hs_p2         <= 1'b1;
      r_vs_p2         <= 1'b1;
      r_glyph_addr_p2 <= 14'd0;
      r_rgb_p3        <= BG_COLOR;
      r_hs_p3         <= 1'b1;
      r_vs_p3         <= 1'b1;
    end else if (pix_en) begin
      // S1 -> S2
      r_de_p1         <= de_in;
      r_hs_p1         <= hs_in;
      r_vs_p1         <= vs_in;
      // S2 -> S3
      r_de_p2         <= r_de_p1;
      r_hs_p2         <= r_hs_p1;
      r_vs_p2         <= r_vs_p1;
      r_glyph_addr_p2 <= {w_ram_q[6:0], r_row_p1, r_col_p1};
      // S3 -> pins
      r_rgb_p3        <= w_rgb;
      r_hs_p3         <= r_hs_p2;
      r_vs_p3         <= r_vs_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      r_row_p1 <= px_y[3:0];
      r_col_p1 <= px_x[2:0];
      r_hit_p1 <= (w_cell == cursor_addr);
      r_hit_p2 <= r_hit_p1;
      r_fg_p2  <= w_ram_q[9:7];
    end
  end

  // r_vs_p1 holds vs_in from the previous strobe, giving the falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink_on  <= 1'b1;
      r_blink_cnt <= '0;
    end else if (pix_en && r_vs_p1 && !vs_in) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // A pending clear_req masks ready so a same-clk write is never accepted.
  assign wr_ready = (r_state == IDLE) && !clear_req && (!WR_BLANK_ONLY || !de_in);
  assign w_wr_acc = wr_valid && wr_ready;
  assign w_wr_ok  = (wr_addr < 12'(CELLS));

  // Writes are suppressed while reset is asserted.
  assign w_we    = rst && ((r_state == CLEAR) || (w_wr_acc && w_wr_ok));
  assign w_waddr = (r_state == CLEAR) ? r_clr_addr : wr_addr;
  assign w_wdata = (r_state == CLEAR) ? {3'b000, SPACE} : wr_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= CLEAR;
      r_clr_addr   <= 12'd0;
      r_clear_done <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      r_wr_err     <= w_wr_acc && !w_wr_ok;
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state    <= CLEAR;
            r_clr_addr <= 12'd0;
          end
        end
        CLEAR: begin
          if (r_clr_addr == LAST_CELL) begin
            r_state      <= IDLE;
            r_clr_addr   <= 12'd0;
            r_clear_done <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 12'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign glyph_addr = r_glyph_addr_p2;
  assign rgb_out    = r_rgb_p3;
  assign hs_out     = r_hs_p3;
  assign vs_out     = r_vs_p3;
  assign wr_err     = r_wr_err;
  assign clear_busy = (r_state == CLEAR);
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_vga_text_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_renderer
// Directed bench for vga_text_renderer with a small glyph ROM model.
// ---------------------------------------------------------------------------
module tb_vga_text_renderer;

  localparam logic [2:0] BG = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  px_x, px_y;
  logic        de_in, hs_in, vs_in;
  logic [13:0] glyph_addr;
  logic        glyph_data = 1'b0;
  logic [2:0]  rgb_out;
  logic        hs_out, vs_out;
  logic        wr_valid, wr_ready;
  logic [11:0] wr_addr;
  logic [9:0]  wr_data;
  logic        wr_err;
  logic        clear_req, clear_busy, clear_done;
  logic        cursor_en;
  logic [11:0] cursor_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic [13:0] ga;
  } vec_t;

  vec_t pend[$];

  vga_text_renderer #(
    .BG_COLOR      (BG),
    .BLINK_FRAMES  (2),
    .WR_BLANK_ONLY (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .px_x        (px_x),
    .px_y        (px_y),
    .de_in       (de_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .glyph_addr  (glyph_addr),
    .glyph_data  (glyph_data),
    .rgb_out     (rgb_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .cursor_en   (cursor_en),
    .cursor_addr (cursor_addr)
  );

  always #5 clk = ~clk;

  // Arbitrary but fixed glyph pattern; every char bit that matters here
  // changes the result, so 0x20 and 0x41 always render differently.
  function automatic logic rom_bit(input logic [13:0] a);
    logic [13:0] m;
    m = a & {7'b1110011, 4'b1011, 3'b101};
    return (^m) ^ (a[1] & a[5]);
  endfunction

  always @(posedge clk) glyph_data <= rom_bit(glyph_addr);

  function automatic logic [2:0] pix(input logic [6:0] ch, input logic [2:0] fg,
                                     input logic [3:0] yo, input logic [2:0] xo,
                                     input logic inv);
    return (rom_bit({ch, yo, xo}) ^ inv) ? fg : BG;
  endfunction

  function automatic vec_t mkvec(input int x, input int y, input logic de,
                                 input logic hs, input logic vs,
                                 input logic [2:0] rgb, input logic [13:0] ga);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.de = de; v.hs = hs; v.vs = vs;
    v.rgb = rgb; v.ga = ga;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel strobe followed by an idle clk; outputs are checked after the
  // idle clk so a pipeline that moves without pix_en is caught.
  task automatic step(input vec_t v);
    vec_t o;
    px_x = v.x; px_y = v.y; de_in = v.de; hs_in = v.hs; vs_in = v.vs;
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    tick();
    pend.push_back(v);
    if (pend.size() >= 2 && pend[pend.size()-2].de)
      chk("glyph_addr", 32'(glyph_addr), 32'(pend[pend.size()-2].ga));
    if (pend.size() == 3) begin
      o = pend.pop_front();
      chk("rgb_out", 32'(rgb_out), 32'(o.rgb));
      chk("hs_out", 32'(hs_out), 32'(o.hs));
      chk("vs_out", 32'(vs_out), 32'(o.vs));
    end
  endtask

  task automatic flush();
    step(mkvec(0, 0, 1'b0, 1'b1, 1'b1, BG, 14'd0));
    step(mkvec(0, 0, 1'b0, 1'b1, 1'b1, BG, 14'd0));
  endtask

  task automatic host_write(input logic [11:0] a, input logic [9:0] d);
    int n;
    n = 0;
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    #1;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("wr_accept", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_clear(input int ign_at);
    int  n;
    int  busy_lo;
    bit  seen;
    n = 0; busy_lo = 0; seen = 1'b0;
    while (!seen && n < 3000) begin
      if (n == ign_at) clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n++;
      if (clear_done) seen = 1'b1;
      else if (!clear_busy) busy_lo++;
    end
    chk("clear_len", 32'(n), 32'd2400);
    chk("clear_busy_hold", 32'(busy_lo), 32'd0);
    chk("clear_busy_end", 32'(clear_busy), 32'd0);
    tick();
    chk("clear_done_pulse", 32'(clear_done), 32'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_rgb", 32'(rgb_out), 32'(BG));
    chk("rst_hs", 32'(hs_out), 32'd1);
    chk("rst_vs", 32'(vs_out), 32'd1);
    chk("rst_glyph_addr", 32'(glyph_addr), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [128];
    int   cnt;

    rst = 1'b0; pix_en = 1'b0; px_x = '0; px_y = '0;
    de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; cursor_en = 1'b0; cursor_addr = '0;

    // Reset, power-on clear, then one pixel from every cell.
    tick();
    tick();
    check_reset_state();
    rst = 1'b1;
    wait_clear(-1);
    for (int c = 0; c < 2400; c++) begin
      logic [3:0] yo;
      logic [2:0] xo;
      yo = 4'(c % 16);
      xo = 3'(c % 8);
      step(mkvec((c % 80) * 8 + int'(xo), (c / 80) * 16 + int'(yo), 1'b1, 1'b1, 1'b1,
                 pix(SPACE_CH(), 3'b000, yo, xo, 1'b0), {7'h20, yo, xo}));
    end
    flush();

    // Character 'A' in green at cell 0, whole glyph.
    host_write(12'd0, {3'b010, 7'h41});
    chk("wr_err_ok_write", 32'(wr_err), 32'd0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++)
        tbl[y*8+x] = mkvec(x, y, 1'b1, 1'b1, 1'b1,
                           pix(7'h41, 3'b010, 4'(y), 3'(x), 1'b0),
                           {7'h41, 4'(y), 3'(x)});
    for (int i = 0; i < 128; i++) step(tbl[i]);
    flush();

    // Out-of-range write: error pulse, nothing written, FSM stays idle.
    host_write(12'd2400, 10'h3FF);
    chk("wr_err_pulse", 32'(wr_err), 32'd1);
    tick();
    chk("wr_err_clears", 32'(wr_err), 32'd0);
    chk("busy_after_err", 32'(clear_busy), 32'd0);
    chk("ready_after_err", 32'(wr_ready), 32'd1);
    step(mkvec(3, 5, 1'b1, 1'b1, 1'b1, pix(7'h41, 3'b010, 4'd5, 3'd3, 1'b0), {7'h41, 4'd5, 3'd3}));
    flush();

    // Writes held off during active video.
    de_in = 1'b1; wr_addr = 12'd5; wr_data = {3'b001, 7'h41}; wr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (wr_ready) cnt++;
      tick();
    end
    chk("blank_only_ready", 32'(cnt), 32'd0);
    de_in = 1'b0;
    #1;
    chk("blank_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("blank_wr_err", 32'(wr_err), 32'd0);
    step(mkvec(42, 7, 1'b1, 1'b1, 1'b1, pix(7'h41, 3'b001, 4'd7, 3'd2, 1'b0), {7'h41, 4'd7, 3'd2}));
    flush();

    // Cursor blink over five frames.
    host_write(12'd81, {3'b011, 7'h41});
    cursor_addr = 12'd81;
    cursor_en   = 1'b1;
    for (int f = 0; f < 5; f++) begin
      logic inv;
      inv = (f == 0) || (f == 1) || (f == 4);
      if (f > 0) begin
        step(mkvec(0, 0, 1'b0, 1'b1, 1'b0, BG, 14'd0));
        step(mkvec(0, 0, 1'b0, 1'b1, 1'b1, BG, 14'd0));
      end
      for (int xo = 0; xo < 4; xo++)
        step(mkvec(8 + xo, 21, 1'b1, 1'b1, 1'b1,
                   pix(7'h41, 3'b011, 4'd5, 3'(xo), inv), {7'h41, 4'd5, 3'(xo)}));
      step(mkvec(2, 21, 1'b1, 1'b1, 1'b1, pix(7'h20, 3'b000, 4'd5, 3'd2, 1'b0), {7'h20, 4'd5, 3'd2}));
      flush();
    end
    cursor_en = 1'b0;

    // Leave non-reset values on the outputs, then reset mid-clear.
    for (int x = 0; x < 3; x++)
      step(mkvec(x, 0, 1'b1, 1'b0, 1'b1, pix(7'h41, 3'b010, 4'd0, 3'(x), 1'b0), {7'h41, 4'd0, 3'(x)}));
    wr_addr = 12'd7; wr_data = {3'b111, 7'h41}; wr_valid = 1'b1; clear_req = 1'b1;
    #1;
    chk("clear_req_priority", 32'(wr_ready), 32'd0);
    tick();
    clear_req = 1'b0; wr_valid = 1'b0;
    chk("clear_busy_start", 32'(clear_busy), 32'd1);
    for (int i = 0; i < 1000; i++) tick();
    rst = 1'b0;
    tick();
    pend.delete();
    check_reset_state();
    rst = 1'b1;
    wait_clear(500);
    step(mkvec(4, 9, 1'b1, 1'b1, 1'b1, pix(7'h20, 3'b000, 4'd9, 3'd4, 1'b0), {7'h20, 4'd9, 3'd4}));
    step(mkvec(60, 3, 1'b1, 1'b1, 1'b1, pix(7'h20, 3'b000, 4'd3, 3'd4, 1'b0), {7'h20, 4'd3, 3'd4}));
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [6:0] SPACE_CH();
    return 7'h20;
  endfunction

endmodule
